alu_shift_seq: RTL
==================

Name: alu_shift_seq

Overview:
Multi-cycle shift/rotate engine for the 68k-style datapath. It runs register-count shifts (count 0..63) over byte, word or long operands, advancing BITS_PER_CYC bit positions per enT3 step. It returns the result and a full X/N/Z/V/C flag set using the same CCR bit layout as the core ALU. It sits beside the ALU and takes over shifts whose count exceeds the ALU's single-bit shifter, which today the microcode loops over.

Parameters:
DATA_W, 32, operand width; legal values 16 or 32. With 16, size=long is treated as word.
BITS_PER_CYC, 1, bit positions shifted per step; power of two in 1..8.
CNT_W, 6, count width; count is taken modulo 2^CNT_W, matching 68k mod-64.

Ports:
clk  in  1  system clock
pwrUp  in  1  synchronous active-high reset
enT3  in  1  phase enable; all state advances only when high (reset excepted)
start  in  1  request; sampled only with enT3 in IDLE or DONE
op  in  3  0 ASL, 1 ASR, 2 LSL, 3 LSR, 4 ROL, 5 ROR, 6 ROXL, 7 ROXR
size  in  2  00 byte, 01 word, 10 long, 11 reserved (treated as word)
count  in  CNT_W  shift count
dataIn  in  DATA_W  operand
xIn  in  1  current X flag
busy  out  1  high in RUN
done  out  1  one-clk pulse when result/ccrOut become valid
result  out  DATA_W  shifted value; bits above size pass through from dataIn
ccrOut  out  5  {X,N,Z,V,C}; index 0=C, 1=V, 2=Z, 3=N, 4=X

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, ccrOut=0. pwrUp mid-RUN aborts the operation; no done is produced.
- States:
  - IDLE: on start&enT3, latch op, size, dataIn, xIn and rem=count. Go to RUN, or to DONE directly if rem=0.
  - RUN: each enT3 shifts k=min(rem,BITS_PER_CYC) positions and decrements rem by k. When rem reaches 0, go to DONE.
  - DONE: done=1 for exactly one clk, then IDLE. A start accepted in DONE behaves as from IDLE (back-to-back).
- start is ignored in RUN. busy=1 only in RUN.
- Latency, count n>0: ceil(n/BITS_PER_CYC) enT3 steps after acceptance, then done on the following clk. For n=0, done follows acceptance immediately.
- Operand width is the size-selected field (8/16/32). Only that field shifts; the upper bits hold.
- Each step is exactly equivalent to k successive 1-bit shifts:
  - ASL/LSL: insert 0 at LSB.
  - LSR: insert 0 at MSB.
  - ASR: replicate MSB.
  - ROL/ROR: rotate within the field.
  - ROXL/ROXR: rotate through X, i.e. field width +1.
- C: last bit shifted out.
  - count=0: C=0, except ROXL/ROXR where C=X.
  - Count ≥ field width for LSL/LSR/ASL: result=0 and C=last bit out (0 beyond width+1).
- X: set equal to C for ASL/ASR/LSL/LSR/ROXL/ROXR when count≠0; unchanged for ROL/ROR and when count=0.
- V: for ASL, 1 if the field MSB changed at any single-bit step; 0 for all other ops.
- N, Z: computed from the final field only.
- result and ccrOut update on entry to DONE and hold until the next DONE or reset.

Decomposition:
- Package alu_shift_pkg:
  - op encodings
  - size encodings
  - CCR index constants CF=0, VF=1, ZF=2, NF=3, XF=4
  - DONE/IDLE/RUN state type
- Sub-module alu_shift_step: combinational.
  - Inputs: field, X, op, size, k (0..BITS_PER_CYC).
  - Outputs: shifted field, new X, last bit out, msbChanged.
  - Instantiated once; the top holds FSM, rem counter and flag accumulation.

Test Plan:
- ASL byte, dataIn=0x00000040, count=2, BITS_PER_CYC=1 → 2 steps; result=0x00000000, X=1 N=0 Z=1 V=1 C=1.
- ASR word, dataIn=0x12348000, count=3 → result=0x1234F000, X=0 N=1 Z=0 V=0 C=0; upper word preserved.
- LSR long, dataIn=0x80000000, count=33, BITS_PER_CYC=4 → 9 steps, busy 9 enT3 steps; result=0, C=X=0, Z=1.
- ROXL word, count=0, xIn=1, dataIn=0x0000A5A5 → done right after accept; result unchanged, X=1 C=1 N=1 Z=0 V=0.
- ROXR word, dataIn=0x00000001, xIn=0, count=1 → result=0x00000000, X=1 C=1 Z=1; start pulsed mid-RUN is ignored.
- pwrUp asserted in RUN → next clk busy=0, done=0, result=0, ccrOut=0; a following start with ROL byte 0x81, count 1 gives 0x03, C=1, X unchanged.

Source files
------------

// File: rtl/alu_shift_pkg.sv
// Shared encodings and helpers for the multi-cycle shift/rotate engine.
// CCR bit positions match the core ALU: {X,N,Z,V,C}.
package alu_shift_pkg;

  typedef enum logic [2:0] {
    OP_ASL  = 3'd0,
    OP_ASR  = 3'd1,
    OP_LSL  = 3'd2,
    OP_LSR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_ROXL = 3'd6,
    OP_ROXR = 3'd7
  } shift_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_LONG = 2'b10,
    SZ_RSVD = 2'b11
  } shift_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } shift_state_e;

  localparam int unsigned CF = 0;
  localparam int unsigned VF = 1;
  localparam int unsigned ZF = 2;
  localparam int unsigned NF = 3;
  localparam int unsigned XF = 4;

  // Reserved size folds to word; long folds to word on a 16-bit datapath.
  function automatic shift_size_e eff_size(input logic [1:0] sz, input logic long_ok);
    case (sz)
      2'b00:   return SZ_BYTE;
      2'b10:   return long_ok ? SZ_LONG : SZ_WORD;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input shift_size_e sz);
    case (sz)
      SZ_BYTE: return 32'h0000_00FF;
      SZ_LONG: return 32'hFFFF_FFFF;
      default: return 32'h0000_FFFF;
    endcase
  endfunction

  function automatic logic [4:0] size_msb(input shift_size_e sz);
    case (sz)
      SZ_BYTE: return 5'd7;
      SZ_LONG: return 5'd31;
      default: return 5'd15;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational step: applies k (0..BITS_PER_CYC) successive 1-bit shifts to
// the size-selected field, returning the new field, X, last bit out and ASL overflow.
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BITS_PER_CYC = 1,
  localparam int unsigned KW          = $clog2(BITS_PER_CYC + 1)
) (
  input  logic [DATA_W-1:0] field_i,
  input  logic              x_i,
  input  shift_op_e         op_i,
  input  shift_size_e       size_i,
  input  logic [KW-1:0]     k_i,
  output logic [DATA_W-1:0] field_o,
  output logic              x_o,
  output logic              c_o,
  output logic              msb_chg_o
);

  localparam int unsigned MW = $clog2(DATA_W);

  logic [DATA_W-1:0] mask;
  logic [MW-1:0]     msb;
  logic [MW-1:0]     msb_m1;
  logic [DATA_W-1:0] f;
  logic              x;
  logic              c;
  logic              chg;
  logic              out;
  logic              fill;

  always_comb begin
    mask   = DATA_W'(size_mask(size_i));
    msb    = MW'(size_msb(size_i));
    msb_m1 = msb - MW'(1);
    f      = field_i & mask;
    x      = x_i;
    c      = 1'b0;
    chg    = 1'b0;
    out    = 1'b0;
    fill   = 1'b0;
    // Unrolled chain of 1-bit shifts; stages beyond k pass the value through.
    for (int unsigned i = 0; i < BITS_PER_CYC; i++) begin
      if (i < 32'(k_i)) begin
        case (op_i)
          OP_ASL, OP_LSL, OP_ROL, OP_ROXL: begin
            out = f[msb];
            if (op_i == OP_ASL && (f[msb] != f[msb_m1])) chg = 1'b1;
            f = (f << 1) & mask;
            if (op_i == OP_ROL)       f[0] = out;
            else if (op_i == OP_ROXL) f[0] = x;
          end
          default: begin
            out = f[0];
            case (op_i)
              OP_ASR:  fill = f[msb];
              OP_ROR:  fill = out;
              OP_ROXR: fill = x;
              default: fill = 1'b0;
            endcase
            f      = f >> 1;
            f[msb] = fill;
          end
        endcase
        c = out;
        if (op_i != OP_ROL && op_i != OP_ROR) x = out;
      end
    end
  end

  assign field_o   = f;
  assign x_o       = x;
  assign c_o       = c;
  assign msb_chg_o = chg;

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate engine beside the ALU: shifts a byte/word/long field
// BITS_PER_CYC positions per enT3 step and reports {X,N,Z,V,C}.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BITS_PER_CYC = 1,
  parameter int unsigned CNT_W        = 6
) (
  input  logic              clk,
  input  logic              pwrUp,
  input  logic              enT3,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        size,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              xIn,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        ccrOut
);

  localparam int unsigned KW = $clog2(BITS_PER_CYC + 1);
  localparam int unsigned MW = $clog2(DATA_W);

  shift_state_e      state_q;
  shift_op_e         op_q;
  shift_size_e       size_q;
  logic [DATA_W-1:0] work_q;
  logic              x_q;
  logic              v_q;
  logic [CNT_W-1:0]  rem_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic [4:0]        ccr_q;

  shift_op_e         acc_op;
  shift_size_e       acc_size;
  logic              acc_c;
  logic [KW-1:0]     k;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] merged_d;
  logic [CNT_W-1:0]  rem_d;
  logic              v_d;

  logic [DATA_W-1:0] stp_field;
  logic              stp_x;
  logic              stp_c;
  logic              stp_chg;

  function automatic logic [4:0] pack_ccr(input logic [DATA_W-1:0] val,
                                          input shift_size_e sz,
                                          input logic x, input logic v, input logic c);
    logic [DATA_W-1:0] m;
    logic [4:0]        flags;
    m         = DATA_W'(size_mask(sz));
    flags     = '0;
    flags[CF] = c;
    flags[VF] = v;
    flags[ZF] = ((val & m) == '0);
    flags[NF] = val[MW'(size_msb(sz))];
    flags[XF] = x;
    return flags;
  endfunction

  always_comb begin
    acc_op   = shift_op_e'(op);
    acc_size = eff_size(size, DATA_W == 32);
    // Zero-count rotate-through-X still reports C = X.
    acc_c    = (acc_op == OP_ROXL || acc_op == OP_ROXR) ? xIn : 1'b0;
    k        = (rem_q < CNT_W'(BITS_PER_CYC)) ? KW'(rem_q) : KW'(BITS_PER_CYC);
    mask_q   = DATA_W'(size_mask(size_q));
    merged_d = (work_q & ~mask_q) | (stp_field & mask_q);
    rem_d    = rem_q - CNT_W'(k);
    v_d      = v_q | stp_chg;
  end

  alu_shift_step #(
    .DATA_W      (DATA_W),
    .BITS_PER_CYC(BITS_PER_CYC)
  ) u_step (
    .field_i  (work_q),
    .x_i      (x_q),
    .op_i     (op_q),
    .size_i   (size_q),
    .k_i      (k),
    .field_o  (stp_field),
    .x_o      (stp_x),
    .c_o      (stp_c),
    .msb_chg_o(stp_chg)
  );

  always_ff @(posedge clk) begin
    if (pwrUp) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ASL;
      size_q   <= SZ_BYTE;
      work_q   <= '0;
      x_q      <= 1'b0;
      v_q      <= 1'b0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ccr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // DONE always lasts a single clk so done is a one-clk pulse.
          if (state_q == ST_DONE) state_q <= ST_IDLE;
          if (enT3 && start) begin
            op_q   <= acc_op;
            size_q <= acc_size;
            work_q <= dataIn;
            x_q    <= xIn;
            v_q    <= 1'b0;
            rem_q  <= count;
            if (count == '0) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= dataIn;
              ccr_q    <= pack_ccr(dataIn, acc_size, xIn, 1'b0, acc_c);
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (enT3) begin
            work_q <= merged_d;
            x_q    <= stp_x;
            v_q    <= v_d;
            rem_q  <= rem_d;
            if (rem_d == '0) begin
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= merged_d;
              ccr_q    <= pack_ccr(merged_d, size_q, stp_x, v_d, stp_c);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ccrOut = ccr_q;

endmodule
